fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
- Parametrised N-digit multiplexed seven-segment scan controller.
- Takes packed BCD digits, decimal points and a per-digit blink mask; decodes and time-multiplexes them onto one segment bus with one-hot active-low digit enables.
- Replaces the fixed six-digit display path.
- Sits between counter/clock logic and the board FND pins; includes its own scan prescaler and blink timer.

Parameters:
- NUM_DIG, 6, number of digits scanned (legal 1..8).
- SCAN_DIV, 50000, clk cycles per digit slot (legal >= 2).
- BLINK_DIV, 25, full scan frames per blink half-period (legal >= 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- i_bcd  input  4*NUM_DIG  packed BCD; digit k = i_bcd[4k+3:4k]; digit 0 is rightmost.
- i_dp  input  NUM_DIG  decimal point per digit, active-high.
- i_blink  input  NUM_DIG  blink mask per digit, active-high.
- i_en  input  1  scan enable; 0 = display dark, timers frozen.
- o_seg  output  7  segments {a,b,c,d,e,f,g}, active-high, registered.
- o_seg_dp  output  1  decimal point, active-high, registered.
- o_seg_enb  output  NUM_DIG  digit enables, active-low one-hot, registered.
- o_frame  output  1  one-cycle pulse at the end of each full scan frame, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: o_seg=0, o_seg_dp=0, o_seg_enb=all ones, o_frame=0.
  - Internal state: prescaler=0, digit index=0, frame counter=0, blink phase=0.
- Asynchronous assertion of rst_n with no clk edge changes nothing.
- Reset has priority over i_en and over all events in the same cycle.
- Prescaler: width $clog2(SCAN_DIV); counts 0..SCAN_DIV-1 and wraps; tick = (prescaler==SCAN_DIV-1).
- Digit index: advances on tick; NUM_DIG-1 wraps to 0.
- Frame end: o_frame=1 in the cycle after the tick on which the index wraps.
- Blink timer: frame counter counts 0..BLINK_DIV-1 on each frame end; blink phase toggles when the frame counter wraps.
- Output registers: load from the current index every cycle, so outputs lag the index by 1 clk.
  - o_seg_enb: bit[index]=0, all other bits 1.
  - o_seg decode (MSB=a): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011; codes 10..15 give 0000000.
  - o_seg_dp = i_dp[index].
- Blink blanking: when i_blink[index]=1 and blink phase=1, o_seg=0 and o_seg_dp=0; o_seg_enb is still driven for that slot.
- i_en=0: on the next edge o_seg_enb=all ones, o_seg=0, o_seg_dp=0, o_frame=0; prescaler, index, frame counter and blink phase hold.
- i_en re-asserted: scanning resumes from the held state with no restart.
- Inputs are sampled every cycle, so a change to i_bcd is visible within 1 clk if its digit is currently selected.

Optional Feature:
- Macro: FND_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit k>0 is blanked (o_seg=0) when it and every digit above it equal 0.
  - Digit 0 is never suppressed.
  - o_seg_dp still follows i_dp and the blink rules.
- Undefined: zeros are always displayed; no suppression logic is synthesised.

Test Plan:
(All scenarios use NUM_DIG=6, SCAN_DIV=4, BLINK_DIV=2.)
1. Reset: rst_n=0 for 3 edges, then 1 -> during reset o_seg_enb=111111, o_seg=0, o_frame=0; first slot shows enb=111110.
2. Scan order: i_bcd=24'h012345, i_blink=0, i_en=1 -> each slot held 4 clk:
   - enb=111110 with seg 1011011 (5).
   - enb=111101 with seg 0110011 (4).
   - Continues through enb=011111 with seg 1111110 (0).
   - o_frame pulses once every 24 clk.
3. Invalid code and dp: digit 2 = 4'hA, i_dp=6'b000100 -> while enb=111011, o_seg=0 and o_seg_dp=1.
4. Blink: i_blink=6'b000001 -> digit 0 shows its segments for 2 frames (48 clk), is blank for the next 2 frames, and the pattern repeats; other digits are unaffected.
5. Enable: drop i_en during the slot with enb=110111 -> next edge enb=111111, seg=0; re-assert after 10 clk -> enb=110111 returns with the remaining prescaler count preserved.
6. Mid-scan reset plus feature: pulse rst_n=0 for one edge at index 3 -> next edge enb=111111, then the scan restarts at index 0.
   - With FND_LZ_BLANK_EN and i_bcd=24'h000042: digits 5..2 blank, digit 1 shows 4, digit 0 shows 2.
   - With FND_LZ_BLANK_EN and i_bcd=0: only digit 0 shows 0.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// ============================================================================
//  Module      : fnd_scan_ctrl
//  Description : N-digit multiplexed seven-segment scan controller. It decodes
//                packed BCD digits and scans them onto one segment bus with
//                one-hot active-low digit enables. Decimal points and per-digit
//                blinking are supported, and the block has its own scan
//                prescaler and blink timer.
//                Optional macro FND_LZ_BLANK_EN enables leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fnd_scan_ctrl #(
  parameter int NUM_DIG   = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NUM_DIG-1:0]   i_bcd,
  input  logic [NUM_DIG-1:0]     i_dp,
  input  logic [NUM_DIG-1:0]     i_blink,
  input  logic                   i_en,
  output logic [6:0]             o_seg,
  output logic                   o_seg_dp,
  output logic [NUM_DIG-1:0]     o_seg_enb,
  output logic                   o_frame
);

  localparam int c_PRESC_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int c_IDX_W   = (NUM_DIG   > 1) ? $clog2(NUM_DIG)   : 1;
  localparam int c_FRM_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_DIG - 1);
  localparam logic [c_FRM_W-1:0]   c_FRM_LAST   = c_FRM_W'(BLINK_DIV - 1);

  logic [c_PRESC_W-1:0] r_presc;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_FRM_W-1:0]   r_frm_cnt;
  logic                 r_blink_ph;

  logic                 w_tick;
  logic                 w_idx_last;
  logic                 w_frame_end;
  logic [3:0]           w_digit;
  logic                 w_dp_sel;
  logic                 w_blink_sel;
  logic                 w_lz_sel;
  logic [NUM_DIG-1:0]   w_enb;
  logic [6:0]           w_seg_dec;
  logic                 w_blank_blink;

  assign w_tick        = (r_presc == c_PRESC_LAST);
  assign w_idx_last    = (r_idx == c_IDX_LAST);
  assign w_frame_end   = w_tick && w_idx_last;
  assign w_blank_blink = w_blink_sel && r_blink_ph;

`ifdef FND_LZ_BLANK_EN
  logic [NUM_DIG-1:0] w_lz_zero;
  logic               w_all_zero;

  // Digit k is a leading zero when it and every digit above it are zero;
  // digit 0 always stays visible.
  always_comb begin
    w_lz_zero  = '0;
    w_all_zero = 1'b1;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      w_all_zero   = w_all_zero && (i_bcd[4*k +: 4] == 4'd0);
      w_lz_zero[k] = w_all_zero;
    end
    w_lz_zero[0] = 1'b0;
  end
`endif

  // Select the current digit's data and build the one-hot active-low enable.
  always_comb begin
    w_digit     = 4'd0;
    w_dp_sel    = 1'b0;
    w_blink_sel = 1'b0;
    w_lz_sel    = 1'b0;
    w_enb       = '1;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (r_idx == c_IDX_W'(k)) begin
        w_digit     = i_bcd[4*k +: 4];
        w_dp_sel    = i_dp[k];
        w_blink_sel = i_blink[k];
        w_enb[k]    = 1'b0;
`ifdef FND_LZ_BLANK_EN
        w_lz_sel    = w_lz_zero[k];
`endif
      end
    end
  end

  // BCD to seven-segment decode, MSB is segment a; non-decimal codes are dark.
  always_comb begin
    case (w_digit)
      4'd0:    w_seg_dec = 7'b1111110;
      4'd1:    w_seg_dec = 7'b0110000;
      4'd2:    w_seg_dec = 7'b1101101;
      4'd3:    w_seg_dec = 7'b1111001;
      4'd4:    w_seg_dec = 7'b0110011;
      4'd5:    w_seg_dec = 7'b1011011;
      4'd6:    w_seg_dec = 7'b1011111;
      4'd7:    w_seg_dec = 7'b1110000;
      4'd8:    w_seg_dec = 7'b1111111;
      4'd9:    w_seg_dec = 7'b1110011;
      default: w_seg_dec = 7'b0000000;
    endcase
  end

  // Scan prescaler, digit index and blink timer; all frozen while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_frm_cnt  <= '0;
      r_blink_ph <= 1'b0;
    end else if (i_en) begin
      r_presc <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
      if (w_tick) begin
        r_idx <= w_idx_last ? '0 : r_idx + c_IDX_W'(1);
      end
      if (w_frame_end) begin
        if (r_frm_cnt == c_FRM_LAST) begin
          r_frm_cnt  <= '0;
          r_blink_ph <= ~r_blink_ph;
        end else begin
          r_frm_cnt  <= r_frm_cnt + c_FRM_W'(1);
        end
      end
    end
  end

  // Output registers follow the current index one clock later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_seg     <= 7'b0000000;
      o_seg_dp  <= 1'b0;
      o_seg_enb <= '1;
      o_frame   <= 1'b0;
    end else if (!i_en) begin
      o_seg     <= 7'b0000000;
      o_seg_dp  <= 1'b0;
      o_seg_enb <= '1;
      o_frame   <= 1'b0;
    end else begin
      o_seg     <= (w_blank_blink || w_lz_sel) ? 7'b0000000 : w_seg_dec;
      o_seg_dp  <= w_blank_blink ? 1'b0 : w_dp_sel;
      o_seg_enb <= w_enb;
      o_frame   <= w_frame_end;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
// ============================================================================
//  Module      : tb_fnd_scan_ctrl
//  Description : Self-checking bench for fnd_scan_ctrl (NUM_DIG=6, SCAN_DIV=4,
//                BLINK_DIV=2). An arithmetic model derives every output from
//                the count of enabled cycles since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fnd_scan_ctrl;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int BD = 2;
  localparam int FR = ND * SD;

`ifdef FND_LZ_BLANK_EN
  localparam logic [6:0] EXP_LEAD0 = 7'b0000000;
`else
  localparam logic [6:0] EXP_LEAD0 = 7'b1111110;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*ND-1:0] i_bcd;
  logic [ND-1:0] i_dp;
  logic [ND-1:0] i_blink;
  logic          i_en;
  logic [6:0]    o_seg;
  logic          o_seg_dp;
  logic [ND-1:0] o_seg_enb;
  logic          o_frame;

  int tests = 0;
  int fails = 0;

  fnd_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_bcd     (i_bcd),
    .i_dp      (i_dp),
    .i_blink   (i_blink),
    .i_en      (i_en),
    .o_seg     (o_seg),
    .o_seg_dp  (o_seg_dp),
    .o_seg_enb (o_seg_enb),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1110011;
      default: return 7'b0000000;
    endcase
  endfunction

  int          e_cnt = 0;
  bit          valid = 0;
  int          m_idx;
  int          m_ph;
  logic        m_blank;
  logic        m_lz;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [ND-1:0] exp_enb;
  logic        exp_frame;

  // Slot = enabled cycles / SCAN_DIV; frame = cycles / (digits*SCAN_DIV).
  always @(posedge clk) begin
    if (!rst_n) begin
      e_cnt = 0; valid = 1;
      exp_seg = 7'd0; exp_dp = 1'b0; exp_enb = '1; exp_frame = 1'b0;
    end else if (!i_en) begin
      exp_seg = 7'd0; exp_dp = 1'b0; exp_enb = '1; exp_frame = 1'b0;
    end else begin
      m_idx   = (e_cnt / SD) % ND;
      m_ph    = ((e_cnt / FR) / BD) % 2;
      m_blank = i_blink[m_idx] && (m_ph == 1);
`ifdef FND_LZ_BLANK_EN
      m_lz    = (m_idx > 0) && ((i_bcd >> (4 * m_idx)) == 0);
`else
      m_lz    = 1'b0;
`endif
      exp_enb   = ~(6'b000001 << m_idx);
      exp_seg   = (m_blank || m_lz) ? 7'd0 : seg_of(i_bcd[4*m_idx +: 4]);
      exp_dp    = m_blank ? 1'b0 : i_dp[m_idx];
      exp_frame = ((e_cnt % FR) == FR - 1);
      e_cnt++;
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      tests++;
      if (o_seg !== exp_seg || o_seg_dp !== exp_dp ||
          o_seg_enb !== exp_enb || o_frame !== exp_frame) begin
        fails++;
        $display("FAIL cmp t=%0t: got seg=%b dp=%b enb=%b frame=%b, expected seg=%b dp=%b enb=%b frame=%b",
                 $time, o_seg, o_seg_dp, o_seg_enb, o_frame, exp_seg, exp_dp, exp_enb, exp_frame);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic wait_enb(input logic [ND-1:0] t, input int lim, input string nm);
    int  n = 0;
    bit  found = 0;
    while (!found && n < lim) begin
      @(negedge clk);
      n++;
      if (o_seg_enb === t) found = 1;
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting enb, got %b expected %b", nm, o_seg_enb, t);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit seen;
    rst_n = 1'b0; i_bcd = 24'h012345; i_dp = '0; i_blink = '0; i_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_enb",   32'(o_seg_enb), 32'h3F);
    chk("rst_seg",   32'(o_seg),     32'h0);
    chk("rst_frame", 32'(o_frame),   32'h0);
    rst_n = 1'b1;

    // scan order
    @(negedge clk);
    chk("slot0_enb", 32'(o_seg_enb), 32'b111110);
    chk("slot0_seg", 32'(o_seg),     32'b1011011);
    repeat (4) @(negedge clk);
    chk("slot1_enb", 32'(o_seg_enb), 32'b111101);
    chk("slot1_seg", 32'(o_seg),     32'b0110011);
    repeat (16) @(negedge clk);
    chk("slot5_enb", 32'(o_seg_enb), 32'b011111);
    chk("slot5_seg", 32'(o_seg),     32'(EXP_LEAD0));

    // frame period
    seen = 0; cyc = 0;
    while (!seen && cyc < 60) begin @(negedge clk); cyc++; seen = (o_frame === 1'b1); end
    chk("frame_first", 32'(seen), 32'h1);
    seen = 0; cyc = 0;
    while (!seen && cyc < 60) begin @(negedge clk); cyc++; seen = (o_frame === 1'b1); end
    chk("frame_period", 32'(cyc), 32'd24);

    // invalid code and decimal point
    i_bcd = 24'h012A45; i_dp = 6'b000100;
    wait_enb(6'b111011, 40, "inv_wait");
    chk("inv_seg", 32'(o_seg),    32'h0);
    chk("inv_dp",  32'(o_seg_dp), 32'h1);

    // enable drop and resume
    i_bcd = 24'h012345; i_dp = '0;
    wait_enb(6'b111011, 40, "en_wait2");
    wait_enb(6'b110111, 40, "en_wait3");
    i_en = 1'b0;
    @(negedge clk);
    chk("en_off_enb", 32'(o_seg_enb), 32'h3F);
    chk("en_off_seg", 32'(o_seg),     32'h0);
    repeat (9) @(negedge clk);
    i_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("en_hold_enb", 32'(o_seg_enb), 32'b110111);
    end
    @(negedge clk);
    chk("en_next_enb", 32'(o_seg_enb), 32'b101111);

    // blink from a fresh reset
    rst_n = 1'b0; i_dp = 6'b000001; i_blink = 6'b000001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("blk_on_seg", 32'(o_seg),    32'b1011011);
    chk("blk_on_dp",  32'(o_seg_dp), 32'h1);
    repeat (48) @(negedge clk);
    chk("blk_off_enb", 32'(o_seg_enb), 32'b111110);
    chk("blk_off_seg", 32'(o_seg),     32'h0);
    chk("blk_off_dp",  32'(o_seg_dp),  32'h0);
    repeat (4) @(negedge clk);
    chk("blk_other_seg", 32'(o_seg), 32'b0110011);
    repeat (44) @(negedge clk);
    chk("blk_back_seg", 32'(o_seg), 32'b1011011);

    // mid-scan reset, then leading-zero patterns
    i_blink = '0; i_dp = '0;
    wait_enb(6'b110111, 40, "mid_wait");
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_enb", 32'(o_seg_enb), 32'h3F);
    rst_n = 1'b1; i_bcd = 24'h000042;
    @(negedge clk);
    chk("restart_enb", 32'(o_seg_enb), 32'b111110);
    chk("lz42_d0",     32'(o_seg),     32'b1101101);
    repeat (4) @(negedge clk);
    chk("lz42_d1", 32'(o_seg), 32'b0110011);
    repeat (16) @(negedge clk);
    chk("lz42_d5", 32'(o_seg), 32'(EXP_LEAD0));
    i_bcd = 24'h000000;
    repeat (4) @(negedge clk);
    chk("lz0_d0", 32'(o_seg), 32'b1111110);
    repeat (4) @(negedge clk);
    chk("lz0_d1", 32'(o_seg), 32'(EXP_LEAD0));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
